// File: rtl/aib_rst_seq_sync.sv
// Multi-channel reset synchroniser/sequencer with soft reset and scan bypass.
// Optional debug ports: define AIB_RST_SEQ_DBG_EN.
module dmux_cell (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic z
);
  assign z = sel ? d1 : d0;
endmodule

module aib_rst_seq_sync #(
  parameter int NUM_RST     = 3,
  parameter int SYNC_DEPTH  = 2,
  parameter int HOLD_CYC    = 4,
  parameter int STAGGER_CYC = 2
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               scan_mode,
  input  logic [NUM_RST-1:0] sw_rst_n,
  output logic [NUM_RST-1:0] sync_rst_n,
  output logic               rst_done
`ifdef AIB_RST_SEQ_DBG_EN
  ,
  output logic [1:0]         dbg_state,
  output logic [$clog2(NUM_RST+1)-1:0] dbg_rel_cnt
`endif
);

  localparam int MX_HS = (HOLD_CYC > STAGGER_CYC) ? HOLD_CYC : STAGGER_CYC;
  localparam int MX    = (MX_HS > NUM_RST) ? MX_HS : NUM_RST;
  localparam int CW    = $clog2(MX + 1);
  localparam logic [CW-1:0] HOLD_LAST =
    CW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
  localparam logic [CW-1:0] STAG_LAST =
    CW'((STAGGER_CYC > 0) ? STAGGER_CYC - 1 : 0);
  localparam logic [CW-1:0] IDX_LAST = CW'(NUM_RST - 1);
  localparam bit REL_ALL = (STAGGER_CYC == 0) || (NUM_RST == 1);

  typedef enum logic [1:0] {
    S_RESET   = 2'd0,
    S_HOLD    = 2'd1,
    S_RELEASE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  rst_sync;
  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         idx_q;
  logic [NUM_RST-1:0]    rel_q;
  logic [NUM_RST-1:0]    sw_q;
  logic                  done_q;
  logic                  go_rel;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], 1'b1};
    end
  end

  assign rst_sync = sync_q[SYNC_DEPTH-1];

  // First channel releases on the same edge the sequencer enters RELEASE.
  assign go_rel = (state_q == S_RESET && rst_sync && HOLD_CYC == 0) ||
                  (state_q == S_HOLD && cnt_q == HOLD_LAST);

`ifdef AIB_RST_SEQ_DBG_EN
  logic [$clog2(NUM_RST+1)-1:0] rcnt_q;
`endif

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
      idx_q   <= '0;
      rel_q   <= '0;
      sw_q    <= '1;
      done_q  <= 1'b0;
`ifdef AIB_RST_SEQ_DBG_EN
      rcnt_q  <= '0;
`endif
    end else begin
      sw_q <= sw_rst_n;
      unique case (state_q)
        S_RESET: begin
          if (rst_sync && HOLD_CYC != 0) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
          end
        end
        S_HOLD: begin
          if (cnt_q != HOLD_LAST) cnt_q <= cnt_q + 1'b1;
        end
        S_RELEASE: begin
          if (cnt_q == STAG_LAST) begin
            cnt_q <= '0;
            for (int k = 0; k < NUM_RST; k++) begin
              if (idx_q == CW'(k)) rel_q[k] <= 1'b1;
            end
`ifdef AIB_RST_SEQ_DBG_EN
            rcnt_q <= rcnt_q + 1'b1;
`endif
            if (idx_q == IDX_LAST) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
        end
      endcase
      if (go_rel) begin
        cnt_q    <= '0;
        rel_q[0] <= 1'b1;
        if (REL_ALL) begin
          rel_q   <= '1;
          state_q <= S_DONE;
          done_q  <= 1'b1;
`ifdef AIB_RST_SEQ_DBG_EN
          rcnt_q  <= ($clog2(NUM_RST+1))'(NUM_RST);
`endif
        end else begin
          state_q <= S_RELEASE;
          idx_q   <= CW'(1);
`ifdef AIB_RST_SEQ_DBG_EN
          rcnt_q  <= ($clog2(NUM_RST+1))'(1);
`endif
        end
      end
    end
  end

`ifdef AIB_RST_SEQ_DBG_EN
  assign dbg_state   = state_q;
  assign dbg_rel_cnt = rcnt_q;
`endif

  for (genvar k = 0; k < NUM_RST; k++) begin : g_mux
    dmux_cell u_mux (
      .d0  (rel_q[k] & sw_q[k]),
      .d1  (i_rst_n),
      .sel (scan_mode),
      .z   (sync_rst_n[k])
    );
  end

  dmux_cell u_mux_done (
    .d0  (done_q),
    .d1  (i_rst_n),
    .sel (scan_mode),
    .z   (rst_done)
  );

endmodule

// File: tb/tb_aib_rst_seq_sync.sv
// Directed bench for aib_rst_seq_sync: default timing plus a
// zero-hold/zero-stagger instance sharing the same stimulus.
module tb_aib_rst_seq_sync;

  logic       clk;
  logic       i_rst_n;
  logic       scan_mode;
  logic [2:0] sw_rst_n;
  logic [2:0] srn_a;
  logic       done_a;
  logic [2:0] srn_z;
  logic       done_z;
`ifdef AIB_RST_SEQ_DBG_EN
  logic [1:0] dst_a;
  logic [1:0] drc_a;
  logic [1:0] dst_z;
  logic [1:0] drc_z;
`endif

  int n_run;
  int n_fail;

  aib_rst_seq_sync #(
    .NUM_RST(3), .SYNC_DEPTH(2), .HOLD_CYC(4), .STAGGER_CYC(2)
  ) u_dut_a (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .scan_mode  (scan_mode),
    .sw_rst_n   (sw_rst_n),
    .sync_rst_n (srn_a),
    .rst_done   (done_a)
`ifdef AIB_RST_SEQ_DBG_EN
    ,
    .dbg_state  (dst_a),
    .dbg_rel_cnt(drc_a)
`endif
  );

  aib_rst_seq_sync #(
    .NUM_RST(3), .SYNC_DEPTH(2), .HOLD_CYC(0), .STAGGER_CYC(0)
  ) u_dut_z (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .scan_mode  (scan_mode),
    .sw_rst_n   (sw_rst_n),
    .sync_rst_n (srn_z),
    .rst_done   (done_z)
`ifdef AIB_RST_SEQ_DBG_EN
    ,
    .dbg_state  (dst_z),
    .dbg_rel_cnt(drc_z)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // i_rst_n must have just gone high; the next posedge is edge 1.
  task automatic seq_check(input int stop);
    logic [2:0] ea;
    logic [2:0] ez;
    for (int e = 1; e <= stop; e++) begin
      @(posedge clk);
      #1;
      ea = {1'(e >= 11), 1'(e >= 9), 1'(e >= 7)};
      ez = (e >= 3) ? 3'b111 : 3'b000;
      check($sformatf("seq_a e%0d", e), srn_a, ea);
      check($sformatf("done_a e%0d", e), done_a, e >= 11);
      check($sformatf("seq_z e%0d", e), srn_z, ez);
      check($sformatf("done_z e%0d", e), done_z, e >= 3);
`ifdef AIB_RST_SEQ_DBG_EN
      check($sformatf("dst_a e%0d", e), dst_a,
            (e <= 2) ? 0 : (e <= 6) ? 1 : (e <= 10) ? 2 : 3);
      check($sformatf("drc_a e%0d", e), drc_a,
            (e >= 11) ? 3 : (e >= 9) ? 2 : (e >= 7) ? 1 : 0);
`endif
    end
  endtask

  initial begin
    n_run     = 0;
    n_fail    = 0;
    i_rst_n   = 1'b1;
    scan_mode = 1'b0;
    sw_rst_n  = 3'b111;
    #2 i_rst_n = 1'b0;
    #1;
    check("rst srn_a", srn_a, 3'b000);
    check("rst done_a", done_a, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst hold srn_a", srn_a, 3'b000);
    check("rst hold srn_z", srn_z, 3'b000);

    // Normal release sequence
    @(negedge clk) i_rst_n = 1'b1;
    seq_check(12);

    // Reset mid-RELEASE, then full re-release
    @(negedge clk) i_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) i_rst_n = 1'b1;
    seq_check(8);
    #2 i_rst_n = 1'b0;
    #1;
    check("mid srn_a", srn_a, 3'b000);
    check("mid done_a", done_a, 1'b0);
    check("mid srn_z", srn_z, 3'b000);
    @(negedge clk) i_rst_n = 1'b1;
    seq_check(12);

    // Soft reset in DONE
    @(negedge clk) sw_rst_n = 3'b101;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("sw srn_a c%0d", i), srn_a, 3'b101);
      check($sformatf("sw done_a c%0d", i), done_a, 1'b1);
    end
    @(negedge clk) sw_rst_n = 3'b111;
    #1;
    check("sw pre-edge srn_a", srn_a, 3'b101);
    @(posedge clk);
    #1;
    check("sw back srn_a", srn_a, 3'b111);
    check("sw back done_a", done_a, 1'b1);

    // Soft reset held low through a channel's scheduled release
    @(negedge clk) i_rst_n = 1'b0;
    sw_rst_n = 3'b011;
    @(negedge clk) i_rst_n = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    check("swpre srn_a", srn_a, 3'b011);
    check("swpre done_a", done_a, 1'b1);
    @(negedge clk) sw_rst_n = 3'b111;
    @(posedge clk);
    #1;
    check("swpre rel srn_a", srn_a, 3'b111);

    // Short glitch on i_rst_n between edges
    @(negedge clk);
    #1 i_rst_n = 1'b0;
    #1;
    check("glitch srn_a", srn_a, 3'b000);
    check("glitch done_a", done_a, 1'b0);
    #1 i_rst_n = 1'b1;
    seq_check(12);

    // Scan bypass
    @(negedge clk) scan_mode = 1'b1;
    i_rst_n = 1'b0;
    #1;
    check("scan lo srn_a", srn_a, 3'b000);
    check("scan lo done_a", done_a, 1'b0);
    #1 i_rst_n = 1'b1;
    #1;
    check("scan hi srn_a", srn_a, 3'b111);
    check("scan hi done_a", done_a, 1'b1);
    check("scan hi srn_z", srn_z, 3'b111);
    #1 i_rst_n = 1'b0;
    #1;
    check("scan lo2 srn_z", srn_z, 3'b000);
    check("scan lo2 done_z", done_z, 1'b0);
    scan_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
